multi_counter: RTL and testbench
================================

Name: multi_counter

Overview:
- Parametrised bank of NUM_CH independent event counters: the next-generation general counter for instrumentation and sequencing logic.
- Each channel supports increment, decrement, synchronous clear and parallel load.
- Each channel has a programmable terminal value, a wrap or saturate mode, a one-cycle boundary-event pulse and a sticky overflow flag.
- Sits beside datapath blocks as a performance/event counter, or as a loop counter inside control FSMs.

Parameters:
- WIDTH, 32: bits per channel counter.
- NUM_CH, 4: number of independent channels (1..32).
- MAX_VAL, 2**WIDTH-1: terminal value; the count range is 0..MAX_VAL inclusive. Must be ≤ 2**WIDTH-1 and ≥ 1.
- SATURATE, 0: 0 = wrap at boundaries, 1 = saturate at boundaries.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr_in  in  NUM_CH  per-channel synchronous clear to 0.
- load_in  in  NUM_CH  per-channel synchronous load.
- load_val_in  in  NUM_CH*WIDTH  load values; channel i occupies bits [i*WIDTH +: WIDTH].
- incr_in  in  NUM_CH  per-channel increment request.
- decr_in  in  NUM_CH  per-channel decrement request.
- ovf_clr_in  in  NUM_CH  per-channel clear of the sticky overflow flag.
- count_out  out  NUM_CH*WIDTH  registered counts, same packing as load_val_in.
- event_out  out  NUM_CH  registered one-cycle boundary-event pulse.
- ovf_out  out  NUM_CH  registered sticky overflow flag.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0, all count_out=0, event_out=0, ovf_out=0 immediately, independent of clk.
- All outputs are registered. An action sampled at edge N is visible on the outputs after edge N; latency is 1 cycle.
- Per-channel priority at each edge: clr_in > load_in > step. Channels are fully independent.
- clr_in=1: count becomes 0; no event is generated.
- load_in=1: count becomes load_val; a value > MAX_VAL is clamped to MAX_VAL. No event is generated.
- Step: incr=1, decr=0 counts up by 1. decr=1, incr=0 counts down by 1. incr=decr=1 holds the count with no event. Both 0 holds.
- Upper boundary (incr at count==MAX_VAL):
  - Wrap mode: count becomes 0.
  - Saturate mode: count stays at MAX_VAL.
  - Either mode: event_out=1 for exactly the following cycle.
- Lower boundary (decr at count==0):
  - Wrap mode: count becomes MAX_VAL.
  - Saturate mode: count stays at 0.
  - Either mode: event_out=1 for the following cycle.
- event_out is 0 in every cycle not caused by a boundary step. Back-to-back boundary steps in saturate mode give event_out high on consecutive cycles.
- ovf_out is set by any boundary event and held until ovf_clr_in=1. If set and clear occur on the same edge, set wins. clr_in and load_in do not affect ovf_out.
- Arithmetic is modulo (MAX_VAL+1) only at the boundaries. The internal compare is done at WIDTH bits and no intermediate value may exceed WIDTH bits.

Optional Feature:
- Macro: MULTI_COUNTER_SNAPSHOT_EN.
- Defined: adds input snap_in (1 bit) and output snap_out (NUM_CH*WIDTH).
  - On an edge with snap_in=1, every channel's count value from before that edge's update is captured into snap_out simultaneously. This gives a coherent multi-channel read.
  - snap_out holds between snapshots and resets to 0 under rst_n.
- Not defined: snap_in and snap_out do not exist. No snapshot registers are synthesised.

Test Plan (WIDTH=8, NUM_CH=2, MAX_VAL=9 unless noted):
- Reset: drive rst_n=0 mid-count with ch0=5, no clk edge → count_out, event_out and ovf_out all 0 immediately. Release rst_n → counts stay 0.
- Wrap up: SATURATE=0, ch0 incr for 12 cycles from 0 → sequence 1..9,0,1,2. event_out[0]=1 only in the cycle count shows 0. ovf_out[0]=1 thereafter. ch1 stays 0.
- Saturate down: SATURATE=1, load ch1=3, then decr for 5 cycles → 2,1,0,0,0. event_out[1]=1 on the last two cycles. ovf_out[1]=1.
- Priority: on the same edge assert clr_in[0], load_in[0] (val 7) and incr_in[0] → count 0. Then load_in[0] with val 200 → count 9 (clamped). Then incr=decr=1 → holds 9, no event.
- Sticky flag: with ovf_out[0]=1, assert ovf_clr_in[0] on a cycle with a boundary event → ovf_out stays 1. Next plain ovf_clr_in → ovf_out 0.
- Snapshot (macro defined): ch0=4 incrementing, ch1=8 decrementing, pulse snap_in → snap_out={8,4}, while count_out shows {7,5} after the edge.

Source files
------------

// File: rtl/multi_counter.sv
// multi_counter: bank of NUM_CH independent event counters.
// Each channel supports clear, load (clamped to MAX_VAL), and increment/decrement
// steps. At the boundaries a channel either wraps or saturates, depending on SATURATE.
// A boundary step produces a one-cycle event pulse and sets a sticky overflow flag.
// Optional feature: define MULTI_COUNTER_SNAPSHOT_EN to add snap_in/snap_out.
// snap_out is a coherent capture of every channel's pre-update count.
module multi_counter #(
    parameter int                WIDTH    = 32,
    parameter int                NUM_CH   = 4,
    parameter logic [WIDTH-1:0]  MAX_VAL  = {WIDTH{1'b1}},
    parameter int                SATURATE = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         clr_in,
    input  logic [NUM_CH-1:0]         load_in,
    input  logic [NUM_CH*WIDTH-1:0]   load_val_in,
    input  logic [NUM_CH-1:0]         incr_in,
    input  logic [NUM_CH-1:0]         decr_in,
    input  logic [NUM_CH-1:0]         ovf_clr_in,
    output logic [NUM_CH*WIDTH-1:0]   count_out,
    output logic [NUM_CH-1:0]         event_out,
    output logic [NUM_CH-1:0]         ovf_out
`ifdef MULTI_COUNTER_SNAPSHOT_EN
    ,
    input  logic                      snap_in,
    output logic [NUM_CH*WIDTH-1:0]   snap_out
`endif
);

    // Clamp a load value into the legal count range 0..MAX_VAL.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return (v > MAX_VAL) ? MAX_VAL : v;
    endfunction

    // Value taken by an increment at MAX_VAL.
    function automatic logic [WIDTH-1:0] upper_next();
        return (SATURATE != 0) ? MAX_VAL : '0;
    endfunction

    // Value taken by a decrement at zero.
    function automatic logic [WIDTH-1:0] lower_next();
        return (SATURATE != 0) ? '0 : MAX_VAL;
    endfunction

    logic [NUM_CH-1:0][WIDTH-1:0] load_val;
    logic [NUM_CH-1:0][WIDTH-1:0] cnt_p0;
    logic [NUM_CH-1:0][WIDTH-1:0] cnt_nxt;
    logic [NUM_CH-1:0]            evt_p0;
    logic [NUM_CH-1:0]            evt_nxt;
    logic [NUM_CH-1:0]            ovf_p0;
    logic [NUM_CH-1:0]            ovf_nxt;

    assign load_val  = load_val_in;
    assign count_out = cnt_p0;
    assign event_out = evt_p0;
    assign ovf_out   = ovf_p0;

    // Per-channel next-state: clear beats load, load beats a step; boundary steps flag events.
    always_comb begin
        cnt_nxt = cnt_p0;
        evt_nxt = '0;
        ovf_nxt = ovf_p0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (clr_in[i]) begin
                cnt_nxt[i] = '0;
            end else if (load_in[i]) begin
                cnt_nxt[i] = clamp_load(load_val[i]);
            end else if (incr_in[i] && !decr_in[i]) begin
                if (cnt_p0[i] == MAX_VAL) begin
                    evt_nxt[i] = 1'b1;
                    cnt_nxt[i] = upper_next();
                end else begin
                    cnt_nxt[i] = cnt_p0[i] + 1'b1;
                end
            end else if (decr_in[i] && !incr_in[i]) begin
                if (cnt_p0[i] == '0) begin
                    evt_nxt[i] = 1'b1;
                    cnt_nxt[i] = lower_next();
                end else begin
                    cnt_nxt[i] = cnt_p0[i] - 1'b1;
                end
            end
            // A new boundary event wins over a same-edge flag clear.
            ovf_nxt[i] = evt_nxt[i] | (ovf_p0[i] & ~ovf_clr_in[i]);
        end
    end

    // ---- stage p0: registered counts, event pulses and sticky flags ----
    // State registers; every output returns to zero as soon as reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p0 <= '0;
            evt_p0 <= '0;
            ovf_p0 <= '0;
        end else begin
            cnt_p0 <= cnt_nxt;
            evt_p0 <= evt_nxt;
            ovf_p0 <= ovf_nxt;
        end
    end

`ifdef MULTI_COUNTER_SNAPSHOT_EN
    // Coherent capture of all channels' counts as they stood before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_out <= '0;
        end else if (snap_in) begin
            snap_out <= cnt_p0;
        end
    end
`else
    // No snapshot state in this build.
`endif

endmodule

// File: tb/tb_multi_counter.sv
// Testbench for multi_counter: WIDTH=8, NUM_CH=2, MAX_VAL=9.
// Two instances share stimulus, one in wrap mode and one in saturate mode.
module tb_multi_counter;

    localparam int W  = 8;
    localparam int NC = 2;
    localparam int MV = 9;

    logic            clk;
    logic            rst_n;
    logic [NC-1:0]   clr, load, incr, decr, ovf_clr;
    logic [NC*W-1:0] load_val;
    logic [NC*W-1:0] count_w, count_s;
    logic [NC-1:0]   event_w, event_s, ovf_w, ovf_s;
`ifdef MULTI_COUNTER_SNAPSHOT_EN
    logic            snap;
    logic [NC*W-1:0] snap_w, snap_s;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model, indexed [mode][channel]; mode 0 = wrap, mode 1 = saturate.
    int mcnt [2][NC];
    int mevt [2][NC];
    int movf [2][NC];
    int msnap[2][NC];

    multi_counter #(.WIDTH(W), .NUM_CH(NC), .MAX_VAL(8'd9), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .clr_in(clr), .load_in(load), .load_val_in(load_val),
        .incr_in(incr), .decr_in(decr), .ovf_clr_in(ovf_clr),
        .count_out(count_w), .event_out(event_w), .ovf_out(ovf_w)
`ifdef MULTI_COUNTER_SNAPSHOT_EN
        , .snap_in(snap), .snap_out(snap_w)
`endif
    );

    multi_counter #(.WIDTH(W), .NUM_CH(NC), .MAX_VAL(8'd9), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .clr_in(clr), .load_in(load), .load_val_in(load_val),
        .incr_in(incr), .decr_in(decr), .ovf_clr_in(ovf_clr),
        .count_out(count_s), .event_out(event_s), .ovf_out(ovf_s)
`ifdef MULTI_COUNTER_SNAPSHOT_EN
        , .snap_in(snap), .snap_out(snap_s)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        clr = '0; load = '0; incr = '0; decr = '0; ovf_clr = '0; load_val = '0;
`ifdef MULTI_COUNTER_SNAPSHOT_EN
        snap = 1'b0;
`endif
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++)
            for (int c = 0; c < NC; c++) begin
                mcnt[m][c] = 0; mevt[m][c] = 0; movf[m][c] = 0; msnap[m][c] = 0;
            end
    endtask

    // One clock edge: advance the model from the current inputs, then settle 1ns past the edge.
    task automatic tick();
        int lv;
        int ev;
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
`ifdef MULTI_COUNTER_SNAPSHOT_EN
            if (snap)
                for (int c = 0; c < NC; c++) msnap[m][c] = mcnt[m][c];
`endif
            for (int c = 0; c < NC; c++) begin
                ev = 0;
                lv = int'(load_val[c*W +: W]);
                if (clr[c]) mcnt[m][c] = 0;
                else if (load[c]) mcnt[m][c] = (lv > MV) ? MV : lv;
                else if (incr[c] && !decr[c]) begin
                    if (mcnt[m][c] == MV) begin
                        ev = 1;
                        mcnt[m][c] = (m == 1) ? MV : 0;
                    end else mcnt[m][c] = mcnt[m][c] + 1;
                end else if (decr[c] && !incr[c]) begin
                    if (mcnt[m][c] == 0) begin
                        ev = 1;
                        mcnt[m][c] = (m == 1) ? 0 : MV;
                    end else mcnt[m][c] = mcnt[m][c] - 1;
                end
                mevt[m][c] = ev;
                if (ev == 1) movf[m][c] = 1;
                else if (ovf_clr[c]) movf[m][c] = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        total_cnt++;
        if ({count_w, count_s, event_w, event_s, ovf_w, ovf_s} !== '0) begin
            $display("FAIL reset_state: got cw=%h cs=%h ew=%b es=%b ow=%b os=%b, want all 0",
                     count_w, count_s, event_w, event_s, ovf_w, ovf_s);
        end else pass_cnt++;
        // Count ch0 up to 5, then pull reset between edges.
        incr = 2'b01;
        repeat (5) tick();
        idle_inputs();
        total_cnt++;
        if (count_w[0 +: W] !== 8'd5) $display("FAIL reset_precount: got %0d want 5", count_w[0 +: W]);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        total_cnt++;
        if ({count_w, count_s, event_w, event_s, ovf_w, ovf_s} !== '0)
            $display("FAIL reset_async: got cw=%h cs=%h, want 0 with no clock edge", count_w, count_s);
        else pass_cnt++;
        #1 rst_n = 1'b1;
        repeat (3) tick();
        total_cnt++;
        if ({count_w, count_s} !== '0) $display("FAIL reset_release: got cw=%h cs=%h want 0", count_w, count_s);
        else pass_cnt++;
    endtask

    task automatic test_wrap_up();
        int exp_c;
        incr = 2'b01;
        for (int k = 0; k < 12; k++) begin
            tick();
            exp_c = (k + 1) % (MV + 1);
            total_cnt++;
            if (count_w[0 +: W] !== exp_c[W-1:0] || event_w[0] !== (k == 9) ||
                ovf_w[0] !== (k >= 9) || count_w[W +: W] !== 8'd0)
                $display("FAIL wrap_up step %0d: got c0=%0d e=%b o=%b c1=%0d want c0=%0d e=%b o=%b c1=0",
                         k, count_w[0 +: W], event_w[0], ovf_w[0], count_w[W +: W], exp_c, k == 9, k >= 9);
            else pass_cnt++;
        end
        idle_inputs();
    endtask

    task automatic test_sat_down();
        int exp_seq [5] = '{2, 1, 0, 0, 0};
        load = 2'b10;
        load_val = {8'd3, 8'd0};
        tick();
        idle_inputs();
        decr = 2'b10;
        for (int k = 0; k < 5; k++) begin
            tick();
            total_cnt++;
            if (count_s[W +: W] !== exp_seq[k][W-1:0] || event_s[1] !== (k >= 3) || ovf_s[1] !== (k >= 3))
                $display("FAIL sat_down step %0d: got c1=%0d e=%b o=%b want c1=%0d e=%b o=%b",
                         k, count_s[W +: W], event_s[1], ovf_s[1], exp_seq[k], k >= 3, k >= 3);
            else pass_cnt++;
        end
        idle_inputs();
    endtask

    task automatic test_priority();
        clr = 2'b01; load = 2'b01; incr = 2'b01; load_val = {8'd0, 8'd7};
        tick();
        idle_inputs();
        total_cnt++;
        if (count_w[0 +: W] !== 8'd0 || count_s[0 +: W] !== 8'd0)
            $display("FAIL prio_clear: got w=%0d s=%0d want 0", count_w[0 +: W], count_s[0 +: W]);
        else pass_cnt++;
        load = 2'b01; load_val = {8'd0, 8'd200};
        tick();
        idle_inputs();
        total_cnt++;
        if (count_w[0 +: W] !== 8'd9 || count_s[0 +: W] !== 8'd9)
            $display("FAIL prio_clamp: got w=%0d s=%0d want 9", count_w[0 +: W], count_s[0 +: W]);
        else pass_cnt++;
        incr = 2'b01; decr = 2'b01;
        tick();
        idle_inputs();
        total_cnt++;
        if (count_w[0 +: W] !== 8'd9 || event_w[0] !== 1'b0 || event_s[0] !== 1'b0)
            $display("FAIL prio_hold: got c=%0d ew=%b es=%b want 9 0 0", count_w[0 +: W], event_w[0], event_s[0]);
        else pass_cnt++;
    endtask

    task automatic test_sticky();
        // ch0 of the wrap instance sits at 9 with its flag set from the wrap test.
        total_cnt++;
        if (ovf_w[0] !== 1'b1) $display("FAIL sticky_pre: got ovf=%b want 1", ovf_w[0]);
        else pass_cnt++;
        incr = 2'b01; ovf_clr = 2'b01;
        tick();
        idle_inputs();
        total_cnt++;
        if (count_w[0 +: W] !== 8'd0 || event_w[0] !== 1'b1 || ovf_w[0] !== 1'b1)
            $display("FAIL sticky_setwins: got c=%0d e=%b o=%b want 0 1 1", count_w[0 +: W], event_w[0], ovf_w[0]);
        else pass_cnt++;
        ovf_clr = 2'b01;
        tick();
        idle_inputs();
        total_cnt++;
        if (ovf_w[0] !== 1'b0 || event_w[0] !== 1'b0)
            $display("FAIL sticky_clear: got o=%b e=%b want 0 0", ovf_w[0], event_w[0]);
        else pass_cnt++;
    endtask

`ifdef MULTI_COUNTER_SNAPSHOT_EN
    task automatic test_snapshot();
        load = 2'b11; load_val = {8'd8, 8'd4};
        tick();
        idle_inputs();
        incr = 2'b01; decr = 2'b10; snap = 1'b1;
        tick();
        idle_inputs();
        total_cnt++;
        if (snap_w !== {8'd8, 8'd4} || count_w !== {8'd7, 8'd5})
            $display("FAIL snapshot: got snap=%h cnt=%h want snap=0804 cnt=0705", snap_w, count_w);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (snap_w !== {8'd8, 8'd4}) $display("FAIL snapshot_hold: got %h want 0804", snap_w);
        else pass_cnt++;
    endtask
`endif

    task automatic test_random();
        int dv;
        int ds;
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < NC; c++) begin
                clr[c]     = ($urandom_range(0, 19) == 0);
                load[c]    = ($urandom_range(0, 14) == 0);
                incr[c]    = ($urandom_range(0, 2) != 0);
                decr[c]    = ($urandom_range(0, 2) == 0);
                ovf_clr[c] = ($urandom_range(0, 9) == 0);
            end
            load_val = 16'($urandom);
`ifdef MULTI_COUNTER_SNAPSHOT_EN
            snap = ($urandom_range(0, 7) == 0);
`endif
            tick();
            for (int m = 0; m < 2; m++)
                for (int c = 0; c < NC; c++) begin
                    dv = (m == 0) ? int'(count_w[c*W +: W]) : int'(count_s[c*W +: W]);
                    ds = 0;
`ifdef MULTI_COUNTER_SNAPSHOT_EN
                    ds = (m == 0) ? int'(snap_w[c*W +: W]) : int'(snap_s[c*W +: W]);
`endif
                    total_cnt++;
                    if (dv !== mcnt[m][c] ||
                        ((m == 0) ? event_w[c] : event_s[c]) !== mevt[m][c][0] ||
                        ((m == 0) ? ovf_w[c] : ovf_s[c]) !== movf[m][c][0]
`ifdef MULTI_COUNTER_SNAPSHOT_EN
                        || ds !== msnap[m][c]
`endif
                       )
                        $display("FAIL random cyc %0d mode %0d ch %0d: got c=%0d e=%b o=%b s=%0d want c=%0d e=%0d o=%0d s=%0d",
                                 n, m, c, dv, (m == 0) ? event_w[c] : event_s[c],
                                 (m == 0) ? ovf_w[c] : ovf_s[c], ds,
                                 mcnt[m][c], mevt[m][c], movf[m][c], msnap[m][c]);
                    else pass_cnt++;
                end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_priority();
        test_sticky();
`ifdef MULTI_COUNTER_SNAPSHOT_EN
        test_snapshot();
`endif
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
